// File: rtl/nn_pkg.sv
// nn_pkg: types and helpers shared by the neural-network layer blocks.
//   layer_state_t : controller FSM states (IDLE, RUN, BIAS, EMIT, WAIT)
//   addr_w(n)     : address/index width for n entries, never less than 1
package nn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_BIAS,
        S_EMIT,
        S_WAIT
    } layer_state_t;

    function automatic int unsigned addr_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mac_acc.sv
// mac_acc: WIDTH-bit unsigned accumulator shared by all neurons of a layer.
// All arithmetic wraps modulo 2^WIDTH.
//   clk, rst   : clock, synchronous active-high reset (clears acc)
//   clr_i      : load init_i into acc (zero or mask at neuron start)
//   init_i     : value loaded on clr_i
//   mac_i      : acc += w_i * x_i (clr_i has priority)
//   w_i, x_i   : multiplicand pair
//   bias_i     : bias operand for the add-bias result
//   acc_o      : current accumulator value
//   acc_bias_o : acc + bias_i, combinational
module mac_acc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] init_i,
    input  logic             mac_i,
    input  logic [WIDTH-1:0] w_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] bias_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] acc_bias_o
);

    logic [WIDTH-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = init_i;
        end else if (mac_i) begin
            acc_d = acc_q + w_i * x_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o      = acc_q;
    assign acc_bias_o = acc_q + bias_i;

endmodule

// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: sequential controller for one fully connected layer.
// One shared MAC is stepped over OUTPUT_SIZE neurons; weights and biases come
// from synchronous memories with one-cycle read latency, results leave one
// per neuron over valid/ready, and done pulses after the last handshake.
// Optional feature macro: LAYER_MASK_EN (adds mask_in / out_mask; the
// accumulator starts from the mask so the unmasked sum is never stored).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, in_data      : start pulse (IDLE only), input vector latched on accept
//   busy                : run in progress
//   w_ren/w_addr/w_rdata: weight memory port, addr = n*INPUT_SIZE + k
//   b_ren/b_addr/b_rdata: bias memory port, addr = n
//   out_valid/out_ready : result handshake with out_idx, out_data
//   done                : one-cycle pulse after the final handshake
module layer_seq_ctrl
    import nn_pkg::*;
#(
    parameter int unsigned INPUT_SIZE  = 5,
    parameter int unsigned OUTPUT_SIZE = 5,
    parameter int unsigned WIDTH       = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [INPUT_SIZE*WIDTH-1:0]                in_data,
    output logic                                       busy,
    output logic                                       w_ren,
    output logic [addr_w(INPUT_SIZE*OUTPUT_SIZE)-1:0]  w_addr,
    input  logic [WIDTH-1:0]                           w_rdata,
    output logic                                       b_ren,
    output logic [addr_w(OUTPUT_SIZE)-1:0]             b_addr,
    input  logic [WIDTH-1:0]                           b_rdata,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [addr_w(OUTPUT_SIZE)-1:0]             out_idx,
    output logic [WIDTH-1:0]                           out_data,
    output logic                                       done
`ifdef LAYER_MASK_EN
    ,
    input  logic [WIDTH-1:0]                           mask_in,
    output logic [WIDTH-1:0]                           out_mask
`endif
);

    localparam int unsigned KW = addr_w(INPUT_SIZE);
    localparam int unsigned NW = addr_w(OUTPUT_SIZE);
    localparam int unsigned AW = addr_w(INPUT_SIZE * OUTPUT_SIZE);
    localparam logic [KW-1:0] K_LAST = KW'(INPUT_SIZE - 1);
    localparam logic [NW-1:0] N_LAST = NW'(OUTPUT_SIZE - 1);

    layer_state_t state_q, state_d;
    logic [NW-1:0]               n_q, n_d;
    logic [KW-1:0]               k_q, k_d;
    logic [INPUT_SIZE*WIDTH-1:0] x_q;
    logic [WIDTH-1:0]            xsel_q, xsel_d;
    logic                        out_valid_q, out_valid_d;
    logic [NW-1:0]               out_idx_q, out_idx_d;
    logic [WIDTH-1:0]            out_data_q, out_data_d;
    logic                        done_q, done_d;
    logic                        load_x, mac_clr, mac_en;
    logic [WIDTH-1:0]            acc_init, acc_val, acc_bias;

`ifdef LAYER_MASK_EN
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] out_mask_q, out_mask_d;
    assign acc_init = mask_in;
    assign out_mask = out_mask_q;
`else
    assign acc_init = '0;
`endif

    mac_acc #(.WIDTH(WIDTH)) u_mac (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (mac_clr),
        .init_i     (acc_init),
        .mac_i      (mac_en),
        .w_i        (w_rdata),
        .x_i        (xsel_q),
        .bias_i     (b_rdata),
        .acc_o      (acc_val),
        .acc_bias_o (acc_bias)
    );

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        k_d         = k_q;
        xsel_d      = xsel_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        load_x      = 1'b0;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
`ifdef LAYER_MASK_EN
        mask_d      = mask_q;
        out_mask_d  = out_mask_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // Blocked during the done cycle so a held start lands one cycle later.
                if (start && !done_q) begin
                    load_x  = 1'b1;
                    mac_clr = 1'b1;
                    n_d     = '0;
                    k_d     = '0;
                    state_d = S_RUN;
`ifdef LAYER_MASK_EN
                    mask_d  = mask_in;
`endif
                end
            end
            S_RUN: begin
                // Weight issued last cycle returns now; xsel_q holds its x.
                mac_en = (k_q != '0);
                for (int unsigned i = 0; i < INPUT_SIZE; i++) begin
                    if (32'(k_q) == i) begin
                        xsel_d = x_q[i*WIDTH +: WIDTH];
                    end
                end
                if (k_q == K_LAST) begin
                    state_d = S_BIAS;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_BIAS: begin
                mac_en  = 1'b1;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                out_data_d  = acc_bias;
                out_idx_d   = n_q;
                out_valid_d = 1'b1;
                state_d     = S_WAIT;
`ifdef LAYER_MASK_EN
                out_mask_d  = mask_q;
`endif
            end
            S_WAIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (n_q == N_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        n_d     = n_q + NW'(1);
                        k_d     = '0;
                        mac_clr = 1'b1;
                        state_d = S_RUN;
`ifdef LAYER_MASK_EN
                        mask_d  = mask_in;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            k_q         <= '0;
            xsel_q      <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
`ifdef LAYER_MASK_EN
            mask_q      <= '0;
            out_mask_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            k_q         <= k_d;
            xsel_q      <= xsel_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
`ifdef LAYER_MASK_EN
            mask_q      <= mask_d;
            out_mask_q  <= out_mask_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (load_x) begin
            x_q <= in_data;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign w_ren     = (state_q == S_RUN);
    assign w_addr    = w_ren ? AW'(32'(n_q) * INPUT_SIZE + 32'(k_q)) : '0;
    assign b_ren     = (state_q == S_BIAS);
    assign b_addr    = b_ren ? n_q : '0;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

    logic unused_acc;
    assign unused_acc = ^acc_val;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed bench for layer_seq_ctrl: a 3-input/2-neuron instance checked
// against a plain-arithmetic layer model every cycle, plus a 1x1 instance.
module tb_layer_seq_ctrl;

    localparam logic [23:0] IN_A = {8'd3, 8'd2, 8'd1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, busy_a, w_ren_a, b_ren_a, out_valid_a, out_ready_a, done_a;
    logic [23:0] in_a;
    logic [2:0]  w_addr_a;
    logic [0:0]  b_addr_a, out_idx_a;
    logic [7:0]  w_rdata_a, b_rdata_a, out_data_a;
    logic [7:0]  mask_val;

    logic        start_b, busy_b, w_ren_b, b_ren_b, out_valid_b, out_ready_b, done_b;
    logic [7:0]  in_b, w_rdata_b, b_rdata_b, out_data_b;
    logic [0:0]  w_addr_b, b_addr_b, out_idx_b;
`ifdef LAYER_MASK_EN
    logic [7:0]  out_mask_a, out_mask_b;
`endif

    layer_seq_ctrl #(.INPUT_SIZE(3), .OUTPUT_SIZE(2), .WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_data(in_a), .busy(busy_a),
        .w_ren(w_ren_a), .w_addr(w_addr_a), .w_rdata(w_rdata_a),
        .b_ren(b_ren_a), .b_addr(b_addr_a), .b_rdata(b_rdata_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_idx(out_idx_a),
        .out_data(out_data_a), .done(done_a)
`ifdef LAYER_MASK_EN
        , .mask_in(mask_val), .out_mask(out_mask_a)
`endif
    );

    layer_seq_ctrl #(.INPUT_SIZE(1), .OUTPUT_SIZE(1), .WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_data(in_b), .busy(busy_b),
        .w_ren(w_ren_b), .w_addr(w_addr_b), .w_rdata(w_rdata_b),
        .b_ren(b_ren_b), .b_addr(b_addr_b), .b_rdata(b_rdata_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_idx(out_idx_b),
        .out_data(out_data_b), .done(done_b)
`ifdef LAYER_MASK_EN
        , .mask_in(8'h00), .out_mask(out_mask_b)
`endif
    );

    // Synchronous memories, one-cycle read latency.
    logic [7:0] wrom_a [6];
    logic [7:0] brom_a [2];
    always @(posedge clk) begin
        if (w_ren_a) w_rdata_a <= wrom_a[w_addr_a];
        if (b_ren_a) b_rdata_a <= brom_a[b_addr_a];
        if (w_ren_b) w_rdata_b <= 8'd2;
        if (b_ren_b) b_rdata_b <= 8'd100;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Layer model: result[n] = (mask + sum_k w[n][k]*x[k] + b[n]) mod 256.
    int xv [3] = '{1, 2, 3};
    function automatic int model_out(input int n);
        int s;
        s = mask_val;
        for (int k = 0; k < 3; k++) s += wrom_a[n*3 + k] * xv[k];
        s += brom_a[n];
        return s % 256;
    endfunction

    int exp_addr_q [$];
    int exp_baddr_q[$];
    int exp_idx_q  [$];
    int exp_data_q [$];
    int got_data   [2];
    int hs_count;

    task automatic push_expect();
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 3; k++) exp_addr_q.push_back(n*3 + k);
            exp_baddr_q.push_back(n);
            exp_idx_q.push_back(n);
            exp_data_q.push_back(model_out(n));
        end
        got_data[0] = -1;
        got_data[1] = -1;
        hs_count    = 0;
    endtask

    task automatic flush_expect();
        exp_addr_q.delete();
        exp_baddr_q.delete();
        exp_idx_q.delete();
        exp_data_q.delete();
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic [0:0] prev_idx;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (w_ren_a) begin
                if (exp_addr_q.size() == 0) check("w_addr_unexpected", 1, 0);
                else check("w_addr", w_addr_a, exp_addr_q.pop_front());
            end else begin
                check("w_addr_idle", w_addr_a, 0);
            end
            if (b_ren_a) begin
                if (exp_baddr_q.size() == 0) check("b_addr_unexpected", 1, 0);
                else check("b_addr", b_addr_a, exp_baddr_q.pop_front());
            end else begin
                check("b_addr_idle", b_addr_a, 0);
            end
            if (prev_stall) begin
                check("hold_valid", out_valid_a, 1);
                check("hold_data", out_data_a, prev_data);
                check("hold_idx", out_idx_a, prev_idx);
            end
            if (out_valid_a && !out_ready_a) check("stall_no_read", w_ren_a | b_ren_a, 0);
            if (out_valid_a && out_ready_a) begin
                if (exp_data_q.size() == 0) begin
                    check("result_unexpected", 1, 0);
                end else begin
                    check("out_idx", out_idx_a, exp_idx_q.pop_front());
                    check("out_data", out_data_a, exp_data_q.pop_front());
                end
`ifdef LAYER_MASK_EN
                check("out_mask", out_mask_a, mask_val);
`endif
                got_data[out_idx_a] = out_data_a;
                hs_count++;
            end
            prev_stall = out_valid_a && !out_ready_a;
            prev_data  = out_data_a;
            prev_idx   = out_idx_a;
        end
    end

    task automatic launch_a();
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    // Counts edges after the accept edge until done; drives stalls and a stray start.
    task automatic wait_done_a(input int exp_edges, input int stall_from, input int stall_to,
                               input int spur_e);
        int  first_valid;
        bit  seen;
        first_valid = -1;
        seen        = 1'b0;
        for (int e = 1; e <= 200 && !seen; e++) begin
            @(posedge clk); #1;
            if (e == 1) check("busy_after_accept", busy_a, 1);
            if (out_valid_a && first_valid < 0) first_valid = e;
            if (e == stall_from) out_ready_a = 1'b0;
            if (e == stall_to)   out_ready_a = 1'b1;
            if (e == spur_e) begin start_a = 1'b1; in_a = 24'h070707; end
            if (e == spur_e + 1) begin start_a = 1'b0; in_a = IN_A; end
            if (done_a) begin
                seen = 1'b1;
                check("done_edge", e, exp_edges);
                check("busy_at_done", busy_a, 0);
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        check("valid_rise_edge", first_valid, 5);
    endtask

    task automatic check_results(input int r0, input int r1);
        check("result_n0", got_data[0], r0);
        check("result_n1", got_data[1], r1);
        check("handshakes", hs_count, 2);
    endtask

    task automatic done_drops();
        @(posedge clk); #1;
        check("done_one_cycle", done_a, 0);
    endtask

    initial begin
        wrom_a = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd0, 8'd255};
        brom_a = '{8'd5, 8'd10};
        rst = 1'b1;
        start_a = 1'b0; in_a = IN_A; out_ready_a = 1'b1; mask_val = 8'h00;
        start_b = 1'b0; in_b = 8'd200; out_ready_b = 1'b1;
        hs_count = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_a, 0);
        check("rst_w_ren", w_ren_a, 0);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_data", out_data_a, 0);
        check("rst_done", done_a, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic run.
        push_expect();
        launch_a();
        wait_done_a(12, -1, -1, -1);
        check_results(11, 9);
        done_drops();

        // out_ready low for 4 cycles while neuron 0 is presented.
        push_expect();
        launch_a();
        wait_done_a(16, 5, 9, -1);
        check_results(11, 9);
        done_drops();

        // Stray start while busy, then start held across the done cycle.
        push_expect();
        launch_a();
        wait_done_a(12, -1, -1, 3);
        check_results(11, 9);
        start_a = 1'b1;
        push_expect();
        @(posedge clk); #1;
        check("start_on_done_ignored", busy_a, 0);
        @(posedge clk); #1;
        check("start_after_done_accepted", busy_a, 1);
        start_a = 1'b0;
        wait_done_a(12, -1, -1, -1);
        check_results(11, 9);
        done_drops();

        // Reset during neuron 1 RUN.
        push_expect();
        launch_a();
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
        end
        check("n0_before_reset", got_data[0], 11);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_w_ren", w_ren_a, 0);
        check("mid_rst_w_addr", w_addr_a, 0);
        check("mid_rst_b_ren", b_ren_a, 0);
        check("mid_rst_out_valid", out_valid_a, 0);
        check("mid_rst_out_idx", out_idx_a, 0);
        check("mid_rst_out_data", out_data_a, 0);
        check("mid_rst_done", done_a, 0);
        rst = 1'b0;
        flush_expect();
        for (int e = 0; e < 4; e++) begin
            @(posedge clk); #1;
            check("no_done_after_abort", done_a, 0);
        end
        push_expect();
        launch_a();
        wait_done_a(12, -1, -1, -1);
        check_results(11, 9);
        done_drops();

        // Single input, single neuron: (200*2 + 100) mod 256 = 244.
        begin
            int  vrise;
            bit  seen;
            vrise = -1;
            seen  = 1'b0;
            start_b = 1'b1;
            @(posedge clk); #1;
            start_b = 1'b0;
            for (int e = 1; e <= 50 && !seen; e++) begin
                @(posedge clk); #1;
                if (out_valid_b && vrise < 0) begin
                    vrise = e;
                    check("b_out_data", out_data_b, 244);
                    check("b_out_idx", out_idx_b, 0);
                end
                if (done_b) begin
                    seen = 1'b1;
                    check("b_done_edge", e, 4);
                end
            end
            if (!seen) check("b_done_timeout", 0, 1);
            check("b_valid_rise_edge", vrise, 3);
        end

`ifdef LAYER_MASK_EN
        mask_val = 8'h5A;
        push_expect();
        launch_a();
        wait_done_a(12, -1, -1, -1);
        check_results(8'h65, 8'h63);
        done_drops();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/layer_seq_ctrl.md
# layer_seq_ctrl

Sequential controller for one fully connected layer. It time-multiplexes a single multiply-accumulate datapath across all OUTPUT_SIZE neurons, replacing the per-neuron combinational weighted-sum instances. It fetches weights and biases from external synchronous ROM/RAM ports, streams one result per neuron through a valid/ready output, and signals completion. It sits between the layer input register and the next layer's input buffer.

## Interface
- `INPUT_SIZE`, default 5: inputs per neuron, ≥1
- `OUTPUT_SIZE`, default 5: neurons, ≥1
- `WIDTH`, default 8: data width of inputs, weights, biases and results
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  pulse; accepted only in IDLE
- `in_data`  in  INPUT_SIZE*WIDTH  input vector, element k at bits [k*WIDTH +: WIDTH]; sampled on accepted start
- `busy`  out  1  high from the cycle after accept until the cycle done pulses
- `w_ren`  out  1  weight read enable
- `w_addr`  out  clog2(INPUT_SIZE*OUTPUT_SIZE)  weight address = n*INPUT_SIZE + k
- `w_rdata`  in  WIDTH  weight data, valid 1 cycle after w_ren
- `b_ren`  out  1  bias read enable
- `b_addr`  out  clog2(OUTPUT_SIZE)  bias address = n
- `b_rdata`  in  WIDTH  bias data, valid 1 cycle after b_ren
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accept
- `out_idx`  out  clog2(OUTPUT_SIZE)  neuron index of out_data
- `out_data`  out  WIDTH  neuron result
- `done`  out  1  one-cycle pulse after the last result is accepted

All address/index widths are at least 1.

## Operation
- FSM states: IDLE, RUN, BIAS, EMIT, WAIT.
- IDLE:
  - On start, latch in_data, set n=0, k=0, acc=0, go to RUN.
  - start in any other state is ignored.
- RUN:
  - Assert w_ren with w_addr=n*INPUT_SIZE+k; k++.
  - Each cycle, accumulate the weight returned for the previous cycle's k: acc += w_rdata*x[k_d].
  - After issuing k=INPUT_SIZE-1, go to BIAS.
- BIAS:
  - Accumulate the last weight.
  - Assert b_ren with b_addr=n; go to EMIT.
- EMIT: register out_data=acc+b_rdata and out_idx=n; set out_valid; go to WAIT.
- WAIT:
  - Hold out_valid, out_data and out_idx stable until out_valid&&out_ready.
  - On that handshake, drop out_valid the next cycle.
  - If n==OUTPUT_SIZE-1: go to IDLE and pulse done.
  - Otherwise: n++, k=0, acc=0, go to RUN.
- Arithmetic: every product and sum is truncated to the WIDTH LSBs (wrap modulo 2^WIDTH), unsigned. This is bit-identical to the combinational layer.
- w_ren and b_ren are low outside RUN and BIAS. Addresses are 0 when their enable is low.
- Reset:
  - All outputs return to 0 and the FSM goes to IDLE.
  - acc, n and k are cleared.
  - No done pulse is produced for an aborted run.
  - This applies mid-operation as well.

## Timing
- Per neuron with out_ready held high: INPUT_SIZE (RUN) + 1 (BIAS) + 1 (EMIT) + 1 (WAIT) = INPUT_SIZE+3 cycles.
- out_valid first rises INPUT_SIZE+2 cycles after the start-accept edge.
- Full layer: OUTPUT_SIZE*(INPUT_SIZE+3) cycles. done is asserted on the cycle after the final handshake; busy falls on that same cycle.
- INPUT_SIZE=1: RUN lasts exactly one cycle.
- out_ready low stalls only in WAIT. Memory reads never stall.
- A start arriving on the same cycle done pulses is ignored. It is accepted one cycle later.

## Configuration
- `LAYER_MASK_EN` defined:
  - Adds input `mask_in` (WIDTH) and output `out_mask` (WIDTH).
  - mask_in is sampled when a neuron enters RUN, and acc is initialised to that mask instead of 0.
  - out_data = true result + mask (mod 2^WIDTH); out_mask carries the mask, aligned with out_data.
  - The unmasked sum never exists in a register.
- Undefined: no mask ports, acc starts at 0, out_data is the plain result.

## Structure
- Shared package `nn_pkg`:
  - FSM state enum `layer_state_t`.
  - Width helper function `addr_w(n)` = max(1, clog2(n)).
- One sub-module `mac_acc`: the WIDTH-bit accumulator with clear/load-mask, multiply-add and add-bias operations. The controller owns the FSM, counters and handshakes.

## Test plan
All scenarios use INPUT_SIZE=3, OUTPUT_SIZE=2, WIDTH=8, in=[1,2,3], weights n0=[1,1,1], n1=[2,0,255], bias=[5,10], unless stated otherwise.
- Basic run, out_ready=1 -> (idx0, 11) then (idx1, 9, wrap check); done exactly 12 cycles after accept.
- out_ready low for 4 cycles during neuron 0 -> out_data=11 held stable; total completion delayed by 4 cycles; no address issued during the stall.
- start pulsed while busy -> ignored; results unchanged; a second start after done reproduces 11 and 9.
- rst asserted in RUN of neuron 1 -> all outputs 0 the next cycle, no done; a fresh start yields 11 and 9.
- INPUT_SIZE=1, OUTPUT_SIZE=1, in=[200], w=[2], b=[100] -> out_data=244, done 4 cycles after accept.
- LAYER_MASK_EN, mask_in=0x5A for both neurons -> out_data=0x65 and 0x63, out_mask=0x5A each.
